// File: rtl/sum_ctrl.sv
// Keypad-driven BCD addition controller: collects two operands digit by digit,
// hands them to an external adder, and shows the sum (or an error on timeout).
module sum_ctrl #(
    parameter int MAX_DIGITS  = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    output logic [4*MAX_DIGITS-1:0]   op_a,
    output logic [4*MAX_DIGITS-1:0]   op_b,
    output logic                      add_start,
    input  logic                      add_done,
    input  logic [4*MAX_DIGITS+3:0]   add_sum,
    output logic [4*MAX_DIGITS+3:0]   disp,
    output logic [2:0]                state_o,
    output logic                      busy
);

    localparam int OPW = 4 * MAX_DIGITS;
    localparam int SW  = OPW + 4;
    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_a_q, op_a_d;
    logic [OPW-1:0]   op_b_q, op_b_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d;
    logic [CW-1:0]    cnt_b_q, cnt_b_d;
    logic [SW-1:0]    res_q, res_d;
    logic [TW-1:0]    tmr_q, tmr_d;

    logic key_digit, key_enter, key_clear, do_clear;

    function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] op, input logic [3:0] d);
        logic [OPW+3:0] t;
        t = {op, d};
        return t[OPW-1:0];
    endfunction

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_enter = key_valid && (key_code == 4'hA);
    assign key_clear = key_valid && (key_code == 4'hC);

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        res_d    = res_q;
        tmr_d    = tmr_q;
        do_clear = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (key_clear) begin
                    do_clear = 1'b1;
                end else if (key_enter) begin
                    state_d = ENTER_B;
                    cnt_b_d = '0;
                end else if (key_digit && (cnt_a_q < CW'(MAX_DIGITS))) begin
                    op_a_d  = shift_in(op_a_q, key_code);
                    cnt_a_d = cnt_a_q + CW'(1);
                end
            end
            ENTER_B: begin
                if (key_clear) begin
                    do_clear = 1'b1;
                end else if (key_enter) begin
                    state_d = START;
                end else if (key_digit && (cnt_b_q < CW'(MAX_DIGITS))) begin
                    op_b_d  = shift_in(op_b_q, key_code);
                    cnt_b_d = cnt_b_q + CW'(1);
                end
            end
            START: begin
                state_d = WAIT;
                tmr_d   = '0;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout
                if (add_done) begin
                    res_d   = add_sum;
                    state_d = SHOW;
                end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ERROR;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            SHOW, ERROR: begin
                if (key_clear) begin
                    do_clear = 1'b1;
                end
            end
            default: state_d = ENTER_A;
        endcase
        if (do_clear) begin
            state_d = ENTER_A;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= ENTER_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            res_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            res_q   <= res_d;
            tmr_q   <= tmr_d;
        end
    end

    // Outputs decode only registered state, never the key or adder inputs
    always_comb begin
        case (state_q)
            ENTER_A:             disp = SW'(op_a_q);
            ENTER_B, START, WAIT: disp = SW'(op_b_q);
            SHOW:                disp = res_q;
            ERROR:               disp = {(MAX_DIGITS + 1){4'hE}};
            default:             disp = '0;
        endcase
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign add_start = (state_q == START);
    assign busy      = (state_q == START) || (state_q == WAIT);
    assign state_o   = state_q;

endmodule

// File: tb/tb_sum_ctrl.sv
// Randomized and directed bench for sum_ctrl against a digit-queue reference model.
module tb_sum_ctrl;

    localparam int TO = 16;
    localparam int MD = 3;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] op_a, op_b;
    logic        add_start;
    logic        add_done;
    logic [15:0] add_sum;
    logic [15:0] disp;
    logic [2:0]  state_o;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase number, entered digits, latched result, WAIT entry stamp
    int          ph;
    int          qa[$];
    int          qb[$];
    logic [15:0] res;
    int          cyc;
    int          t_enter;
    int          starts_seen;

    sum_ctrl #(.MAX_DIGITS(MD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .n_reset(n_reset), .key_valid(key_valid), .key_code(key_code),
        .op_a(op_a), .op_b(op_b), .add_start(add_start), .add_done(add_done),
        .add_sum(add_sum), .disp(disp), .state_o(state_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] qval(input int q[$]);
        logic [15:0] v = 16'h0;
        foreach (q[i]) v = (v << 4) + 16'(q[i]);
        return v;
    endfunction

    task automatic model_clear();
        ph = 0;
        qa.delete();
        qb.delete();
        res = 16'h0;
    endtask

    task automatic model(input logic kv, input logic [3:0] kc, input logic dn,
                         input logic [15:0] sm, input logic rn);
        if (!rn) begin
            model_clear();
            return;
        end
        case (ph)
            0, 1: if (kv) begin
                if (kc == 4'hC) model_clear();
                else if (kc == 4'hA) ph = ph + 1;
                else if (kc <= 4'd9) begin
                    if (ph == 0 && qa.size() < MD) qa.push_back(int'(kc));
                    if (ph == 1 && qb.size() < MD) qb.push_back(int'(kc));
                end
            end
            2: begin
                ph = 3;
                t_enter = cyc;
            end
            3: begin
                if (dn) begin
                    res = sm;
                    ph = 4;
                end else if (cyc - t_enter >= TO) ph = 5;
            end
            default: if (kv && kc == 4'hC) model_clear();
        endcase
    endtask

    task automatic compare_all();
        logic [15:0] exp_disp;
        case (ph)
            0:       exp_disp = qval(qa);
            1, 2, 3: exp_disp = qval(qb);
            4:       exp_disp = res;
            default: exp_disp = 16'hEEEE;
        endcase
        check("state_o", 32'(state_o), 32'(ph));
        check("disp", 32'(disp), 32'(exp_disp));
        check("op_a", 32'(op_a), 32'(qval(qa)));
        check("op_b", 32'(op_b), 32'(qval(qb)));
        check("add_start", 32'(add_start), 32'(ph == 2));
        check("busy", 32'(busy), 32'(ph == 2 || ph == 3));
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic dn,
                        input logic [15:0] sm, input logic rn);
        key_valid = kv;
        key_code  = kc;
        add_done  = dn;
        add_sum   = sm;
        n_reset   = rn;
        @(posedge clk);
        cyc++;
        model(kv, kc, dn, sm, rn);
        #1;
        if (add_start) starts_seen++;
        compare_all();
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic reach_wait();
        key(4'h1); key(4'hA); key(4'h2); key(4'hA);
        idle();
    endtask

    initial begin
        cyc = 0;
        t_enter = 0;
        starts_seen = 0;
        model_clear();
        step(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);

        // basic 123 + 456
        key(4'h1); key(4'h2); key(4'h3); key(4'hA);
        key(4'h4); key(4'h5); key(4'h6);
        starts_seen = 0;
        key(4'hA);
        idle();
        check("sum_op_a", 32'(op_a), 32'h123);
        check("sum_op_b", 32'(op_b), 32'h456);
        step(1'b0, 4'h0, 1'b1, 16'h0579, 1'b1);
        check("sum_pulses", 32'(starts_seen), 32'd1);
        check("sum_disp", 32'(disp), 32'h0579);
        check("sum_state", 32'(state_o), 32'd4);
        key(4'hC);

        // digit overflow
        key(4'h9); key(4'h8); key(4'h7); key(4'h6);
        check("ovf_op_a", 32'(op_a), 32'h987);
        check("ovf_disp", 32'(disp), 32'h0987);
        key(4'hC);

        // timeout
        reach_wait();
        for (int i = 0; i < TO; i++) idle();
        check("to_state", 32'(state_o), 32'd5);
        check("to_disp", 32'(disp), 32'hEEEE);
        key(4'h7);
        check("to_ignore", 32'(state_o), 32'd5);
        key(4'hC);
        check("to_clr_state", 32'(state_o), 32'd0);
        check("to_clr_ops", 32'({op_a, op_b}), 32'h0);

        // done on the final allowed cycle beats the timeout
        reach_wait();
        for (int i = 0; i < TO - 1; i++) idle();
        step(1'b0, 4'h0, 1'b1, 16'h0999, 1'b1);
        check("edge_state", 32'(state_o), 32'd4);
        check("edge_disp", 32'(disp), 32'h0999);
        key(4'hC);

        // reset mid-WAIT, late done ignored
        reach_wait();
        step(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 16'h1234, 1'b1);
        check("rstw_state", 32'(state_o), 32'd0);
        check("rstw_disp", 32'(disp), 32'h0);

        // keys ignored while waiting
        reach_wait();
        key(4'hC); key(4'h5);
        step(1'b0, 4'h0, 1'b1, 16'h0042, 1'b1);
        check("wkey_disp", 32'(disp), 32'h0042);
        check("wkey_state", 32'(state_o), 32'd4);
        key(4'hC);

        // unused codes ignored, count continues from 1
        key(4'hB); key(4'hF); key(4'h5);
        check("junk_op_a", 32'(op_a), 32'h005);
        key(4'h6); key(4'h7); key(4'h8);
        check("junk_cnt", 32'(op_a), 32'h567);
        key(4'hC);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       kv, dn, rn;
            logic [3:0] kc;
            kv = ($urandom % 3) == 0;
            kc = 4'($urandom % 16);
            dn = ($urandom % 10) == 0;
            rn = ($urandom % 200) != 0;
            step(kv, kc, dn, 16'($urandom), rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_ctrl.md
SUM_CTRL -- requirements
Module: sum_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, meaning BCD digits per operand (op width = 4*MAX_DIGITS).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning cycles allowed between add_start and add_done.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port n_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe, key_code valid.
REQ-006 SHALL have port key_code  input  4  0x0-0x9 digit, 0xA enter, 0xC clear, others ignored.
REQ-007 SHALL have port op_a  output  12  operand A, BCD, to adder.
REQ-008 SHALL have port op_b  output  12  operand B, BCD, to adder.
REQ-009 SHALL have port add_start  output  1  one-cycle pulse requesting a sum.
REQ-010 SHALL have port add_done  input  1  adder result valid strobe.
REQ-011 SHALL have port add_sum  input  16  adder result, BCD.
REQ-012 SHALL have port disp  output  16  value for display (BCD, or 16'hEEEE on error).
REQ-013 SHALL have port state_o  output  3  current state encoding.
REQ-014 SHALL have port busy  output  1  high in START and WAIT.

Function
REQ-015 SHALL implement states ENTER_A=0, ENTER_B=1, START=2, WAIT=3, SHOW=4, ERROR=5, driven on state_o.
REQ-016 In ENTER_A, a digit key with fewer than MAX_DIGITS entered SHALL update op_a <= {op_a[7:0], key_code} and increment the A digit count.
REQ-017 A digit key with MAX_DIGITS already entered SHALL be ignored (op and count unchanged).
REQ-018 Enter (0xA) in ENTER_A SHALL move to ENTER_B with the B digit count at 0 and op_b unchanged at 0.
REQ-019 ENTER_B SHALL accept digits into op_b with the same rules as REQ-016/017.
REQ-020 Enter in ENTER_B SHALL move to START; START SHALL assert add_start for exactly one cycle, then move to WAIT.
REQ-021 In WAIT, add_done SHALL latch add_sum into the result register and move to SHOW on the next edge.
REQ-022 WAIT SHALL count cycles from entry; if add_done has not arrived when TIMEOUT_CYC cycles have elapsed, SHALL move to ERROR.
REQ-023 add_done arriving on the timeout cycle SHALL take priority (move to SHOW).
REQ-024 add_done outside WAIT SHALL be ignored.
REQ-025 key_valid in START or WAIT SHALL be ignored, including clear.
REQ-026 Clear (0xC) in ENTER_A, ENTER_B, SHOW or ERROR SHALL zero op_a, op_b, both counts and result, and move to ENTER_A.
REQ-027 Digit or enter in SHOW or ERROR SHALL be ignored; only clear leaves these states.
REQ-028 Key codes 0xB, 0xD, 0xE, 0xF SHALL be ignored in every state.
REQ-029 disp SHALL be {4'h0, op_a} in ENTER_A; {4'h0, op_b} in ENTER_B, START and WAIT; the result in SHOW; 16'hEEEE in ERROR.
REQ-030 All outputs SHALL be registered or decoded only from registered state, with no combinational path from key_* or add_* to outputs.
REQ-031 op_a and op_b SHALL hold stable from the START entry until the next clear.

Reset
REQ-032 When n_reset=0 at a rising edge, the block SHALL enter ENTER_A with op_a=0, op_b=0, result=0, counts=0, timeout counter=0, add_start=0, busy=0, disp=0, state_o=0.
REQ-033 Reset SHALL take effect from any state, including mid-WAIT; a later add_done SHALL be ignored.

Verification
REQ-034 Keys 1,2,3,A,4,5,6,A -> op_a=12'h123, op_b=12'h456, one add_start pulse; add_done with add_sum=16'h0579 -> disp=16'h0579, state_o=4.
REQ-035 Keys 9,8,7,6 in ENTER_A -> op_a=12'h987 (fourth digit ignored), disp=16'h0987.
REQ-036 Reach WAIT, withhold add_done for TIMEOUT_CYC cycles -> state_o=5, disp=16'hEEEE; then key C -> state_o=0, all ops 0.
REQ-037 Reach WAIT, assert n_reset=0 for one cycle, then pulse add_done -> state_o=0, disp=0, no SHOW.
REQ-038 In WAIT, press C and a digit, then deliver add_done=16'h0042 -> keys ignored, disp=16'h0042.
REQ-039 Keys 0xB, 0xF in ENTER_A, then 5 -> op_a=12'h005, count=1.
